// File: rtl/vred_acc.sv
// Vector reduction accumulator: sums all lanes of Len_i beats into a wide accumulator and returns one scalar.
// Optional VRED_SAT_EN clamps the result to RESW and reports the clamp on Ovf_o; otherwise the result is truncated.
module vred_acc #(
  parameter int VECW = 32,
  parameter int DW   = 8,
  parameter int ACCW = 20,
  parameter int CNTW = 8,
  parameter int RESW = 16
) (
  input  logic            Clk_i,
  input  logic            Rst_i,
  input  logic            Start_i,
  input  logic [CNTW-1:0] Len_i,
  input  logic            Signed_i,
  input  logic            VecValid_i,
  input  logic [VECW-1:0] Vec_i,
  output logic            VecReady_o,
  output logic            Busy_o,
  output logic            ResValid_o,
  output logic [RESW-1:0] Res_o,
  input  logic            ResReady_i,
  output logic            Ovf_o
);

  localparam int LANES = VECW / DW;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t          state;
  logic [CNTW-1:0] remaining;
  logic            signed_mode;
  logic            s1_vld;
  logic [ACCW-1:0] s1_sum;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] lane_sum;
  logic [ACCW-1:0] acc_next;
  logic [RESW-1:0] res_next;
  logic            ovf_next;
  logic            accept;

  assign accept   = (state == ACC) && VecValid_i && VecReady_o;
  assign acc_next = acc + (s1_vld ? s1_sum : '0);

  // Sign extension is gated by the mode latched at Start_i, not the live input.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + {{(ACCW-DW){signed_mode & Vec_i[i*DW+DW-1]}}, Vec_i[i*DW +: DW]};
    end
  end

`ifdef VRED_SAT_EN
  always_comb begin
    res_next = acc_next[RESW-1:0];
    ovf_next = 1'b0;
    if (signed_mode) begin
      if (!acc_next[ACCW-1] && (acc_next[ACCW-2:RESW-1] != '0)) begin
        res_next = {1'b0, {(RESW-1){1'b1}}};
        ovf_next = 1'b1;
      end else if (acc_next[ACCW-1] && (acc_next[ACCW-2:RESW-1] != '1)) begin
        res_next = {1'b1, {(RESW-1){1'b0}}};
        ovf_next = 1'b1;
      end
    end else if (acc_next[ACCW-1:RESW] != '0) begin
      res_next = '1;
      ovf_next = 1'b1;
    end
  end
`else
  assign res_next = acc_next[RESW-1:0];
  assign ovf_next = 1'b0;
`endif

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state       <= IDLE;
      remaining   <= '0;
      signed_mode <= 1'b0;
      s1_vld      <= 1'b0;
      s1_sum      <= '0;
      acc         <= '0;
      VecReady_o  <= 1'b0;
      Busy_o      <= 1'b0;
      ResValid_o  <= 1'b0;
      Res_o       <= '0;
      Ovf_o       <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_sum <= lane_sum;
      acc <= acc_next;
      case (state)
        IDLE: begin
          if (Start_i) begin
            signed_mode <= Signed_i;
            acc         <= '0;
            Ovf_o       <= 1'b0;
            Busy_o      <= 1'b1;
            if (Len_i != '0) begin
              remaining  <= Len_i;
              VecReady_o <= 1'b1;
              state      <= ACC;
            end else begin
              Res_o      <= '0;
              ResValid_o <= 1'b1;
              state      <= DONE;
            end
          end
        end
        ACC: begin
          if (accept) begin
            remaining <= remaining - 1'b1;
            if (remaining == CNTW'(1)) begin
              VecReady_o <= 1'b0;
              state      <= DRAIN;
            end
          end
        end
        // The single pipeline stage holds the final beat here; it lands in acc_next this cycle.
        DRAIN: begin
          Res_o      <= res_next;
          Ovf_o      <= ovf_next;
          ResValid_o <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (ResReady_i) begin
            ResValid_o <= 1'b0;
            Busy_o     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vred_acc.sv
// Self-checking bench for vred_acc; reference sums lanes with plain integer arithmetic.
module tb_vred_acc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        sgn = 1'b0;
  logic        vec_valid = 1'b0;
  logic [31:0] vec = '0;
  logic        vec_ready;
  logic        busy;
  logic        res_valid;
  logic [15:0] res;
  logic        res_ready = 1'b0;
  logic        ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] beats [256];
  logic [15:0] got_res;
  logic        got_ovf;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vred_acc dut (
    .Clk_i(clk), .Rst_i(rst), .Start_i(start), .Len_i(len), .Signed_i(sgn),
    .VecValid_i(vec_valid), .Vec_i(vec), .VecReady_o(vec_ready), .Busy_o(busy),
    .ResValid_o(res_valid), .Res_o(res), .ResReady_i(res_ready), .Ovf_o(ovf)
  );

  function automatic void model(input bit s, input int n, output logic [15:0] r, output logic o);
    int sum;
    logic [7:0] b;
    byte sb;
    sum = 0;
    for (int i = 0; i < n; i++)
      for (int l = 0; l < 4; l++) begin
        b = beats[i][l*8 +: 8];
        sb = b;
        sum += s ? int'(sb) : int'(b);
      end
    r = sum[15:0];
    o = 1'b0;
`ifdef VRED_SAT_EN
    if (s) begin
      if (sum > 32767) begin r = 16'h7FFF; o = 1'b1; end
      else if (sum < -32768) begin r = 16'h8000; o = 1'b1; end
    end else if (sum > 65535) begin
      r = 16'hFFFF; o = 1'b1;
    end
`endif
  endfunction

  // gap = percent of idle cycles on VecValid, or -1 for strict alternation.
  task automatic run_red(input string name, input bit s, input int n, input int gap,
                         input int hold, input bit poke);
    logic [15:0] er, cap_r;
    logic        eo, cap_o;
    int idx, t, last;
    model(s, n, er, eo);
    @(negedge clk);
    start = 1'b1; len = n[7:0]; sgn = s; last = cyc;
    @(negedge clk);
    start = 1'b0; len = '0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_start got=%b exp=1", name, busy); end
    if (n != 0) begin
      checks++;
      if (vec_ready !== 1'b1) begin failures++; $display("FAIL %s ready_after_start got=%b exp=1", name, vec_ready); end
    end
    idx = 0; t = 0;
    while (idx < n && t < 5000) begin
      vec = beats[idx];
      vec_valid = (gap < 0) ? (t % 2 == 0) : ($urandom_range(99) >= gap);
      if (vec_valid && vec_ready) begin last = cyc; idx++; end
      @(negedge clk);
      t++;
    end
    vec_valid = 1'b0;
    checks++;
    if (idx != n) begin failures++; $display("FAIL %s beat_timeout got=%0d exp=%0d", name, idx, n); end
    checks++;
    if (vec_ready !== 1'b0) begin failures++; $display("FAIL %s ready_after_last got=%b exp=0", name, vec_ready); end
    t = 0;
    while (res_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (res_valid !== 1'b1 || (cyc - last) != ((n == 0) ? 1 : 2)) begin
      failures++; $display("FAIL %s result_latency got=%0d exp=%0d", name, cyc - last, (n == 0) ? 1 : 2);
    end
    checks++;
    if (res !== er) begin failures++; $display("FAIL %s res got=%h exp=%h", name, res, er); end
    checks++;
    if (ovf !== eo) begin failures++; $display("FAIL %s ovf got=%b exp=%b", name, ovf, eo); end
    cap_r = res; cap_o = ovf;
    got_res = res; got_ovf = ovf;
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      start = poke && (h == 1);
      len = 8'd3;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res !== cap_r || ovf !== cap_o) begin
        failures++; $display("FAIL %s hold_stable got=%b/%h/%b exp=1/%h/%b", name, res_valid, res, ovf, cap_r, cap_o);
      end
    end
    res_ready = 1'b1; start = poke; len = 8'd3;
    @(negedge clk);
    res_ready = 1'b0; start = 1'b0; len = '0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s after_handshake got=%b/%b exp=0/0", name, res_valid, busy);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (busy !== 1'b0 || vec_ready !== 1'b0 || res_valid !== 1'b0 || res !== 16'h0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL %s reset_vals got=busy%b rdy%b vld%b res%h ovf%b exp=all0", name, busy, vec_ready, res_valid, res, ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    beats[0] = 32'h01020304; beats[1] = 32'h10101010;
    run_red("basic", 1'b0, 2, 0, 0, 1'b0);
    checks++;
    if (got_res !== 16'h004A) begin failures++; $display("FAIL basic_const got=%h exp=004a", got_res); end
  endtask

  task automatic test_ones();
    beats[0] = 32'hFFFFFFFF;
    run_red("ones_signed", 1'b1, 1, 0, 1, 1'b0);
    checks++;
    if (got_res !== 16'hFFFC) begin failures++; $display("FAIL ones_signed_const got=%h exp=fffc", got_res); end
    run_red("ones_unsigned", 1'b0, 1, 0, 0, 1'b0);
    checks++;
    if (got_res !== 16'h03FC) begin failures++; $display("FAIL ones_unsigned_const got=%h exp=03fc", got_res); end
  endtask

  task automatic test_len255();
    logic [15:0] eu, es;
    for (int i = 0; i < 255; i++) beats[i] = 32'hFFFFFFFF;
    run_red("max_unsigned", 1'b0, 255, 0, 0, 1'b0);
`ifdef VRED_SAT_EN
    eu = 16'hFFFF; es = 16'h8000;
`else
    eu = 16'hF804; es = 16'h0200;
`endif
    checks++;
    if (got_res !== eu) begin failures++; $display("FAIL max_unsigned_const got=%h exp=%h", got_res, eu); end
    for (int i = 0; i < 255; i++) beats[i] = 32'h80808080;
    run_red("min_signed", 1'b1, 255, 0, 0, 1'b0);
    checks++;
    if (got_res !== es) begin failures++; $display("FAIL min_signed_const got=%h exp=%h", got_res, es); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) beats[i] = 32'h01010101;
    run_red("backpressure", 1'b0, 4, -1, 5, 1'b1);
    checks++;
    if (got_res !== 16'h0010) begin failures++; $display("FAIL backpressure_const got=%h exp=0010", got_res); end
  endtask

  task automatic test_len0();
    run_red("len0", 1'b1, 0, 0, 2, 1'b0);
    checks++;
    if (got_res !== 16'h0000) begin failures++; $display("FAIL len0_const got=%h exp=0000", got_res); end
  endtask

  task automatic test_reset_mid();
    int fed;
    @(negedge clk);
    start = 1'b1; len = 8'd5; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    fed = 0;
    for (int t = 0; t < 20 && fed < 3; t++) begin
      vec = 32'h7F7F7F7F; vec_valid = 1'b1;
      if (vec_ready) fed++;
      @(negedge clk);
    end
    vec_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset_mid");
    beats[0] = 32'h01010101;
    run_red("after_reset", 1'b0, 1, 0, 0, 1'b0);
    checks++;
    if (got_res !== 16'h0004) begin failures++; $display("FAIL after_reset_const got=%h exp=0004", got_res); end
  endtask

  task automatic test_random();
    int n;
    bit s;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(20, 1);
      s = $urandom_range(1);
      for (int i = 0; i < n; i++) beats[i] = $urandom;
      run_red("random", s, n, 30, $urandom_range(3), $urandom_range(1));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ones();
    test_len255();
    test_backpressure();
    test_len0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
